// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared defaults and the duty-vector slicing helper for the multi-channel PWM.
//   CH_DEF          default channel count
//   CW_DEF          default counter / duty / period width
//   PERIOD_RST_DEF  period loaded at reset (5000-cycle frame)
//   duty_lsb()      lsb of channel k inside the packed duty vector
// Optional build macro used by the PWM files: PWM_CENTER_ALIGNED_EN.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int CH_DEF         = 4;
  localparam int CW_DEF         = 13;
  localparam int PERIOD_RST_DEF = 4999;

  // Channel k occupies bits [k*cw +: cw] of the packed duty vector.
  function automatic int duty_lsb(input int k, input int cw);
    return k * cw;
  endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// -----------------------------------------------------------------------------
// pwm_cmp_ch
// One PWM channel: duty staging register, duty shadow register, compare
// against the shared counter and the registered output.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   en_i            run enable (low forces the output low)
//   load_i          capture strobe for duty_i
//   upd_i           shadow update point (frame wrap, or every clock while stopped)
//   pend_i          staged value waiting to be applied
//   cnt_i           shared frame counter
//   duty_i          this channel's duty input
//   pwm_o           registered PWM output
// Counting mode (PWM_CENTER_ALIGNED_EN) is handled entirely in the top level.
// -----------------------------------------------------------------------------
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic          upd_i,
  input  logic          pend_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] duty_i,
  output logic          pwm_o
);

  logic [CW-1:0] stg_q, stg_d;
  logic [CW-1:0] sh_q,  sh_d;
  logic          pwm_q, pwm_d;

  // Next-state for staging, shadow and compare output.
  always_comb begin
    stg_d = stg_q;
    sh_d  = sh_q;
    pwm_d = 1'b0;
    if (load_i) begin
      stg_d = duty_i;
    end else begin
      stg_d = stg_q;
    end
    // A load landing on the update point bypasses staging.
    if (upd_i && load_i) begin
      sh_d = duty_i;
    end else if (upd_i && pend_i) begin
      sh_d = stg_q;
    end else begin
      sh_d = sh_q;
    end
    // Compare uses the shadow in force this cycle; a new shadow first
    // meets cnt=0, so no runt pulse appears at the wrap.
    pwm_d = en_i && (cnt_i < sh_q);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stg_q <= CW'(1'b0);
      sh_q  <= CW'(1'b0);
      pwm_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      sh_q  <= sh_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
// Multi-channel PWM with a shared frame counter and double-buffered
// period/duty registers that switch over only at a frame boundary.
// Ports:
//   CLK, RSTn    clock, asynchronous active-low reset
//   en           run enable; low holds the counter at 0 and outputs low
//   load         one-cycle strobe capturing period_in / duty_in
//   period_in    terminal count P
//   duty_in      packed duties, channel k at [k*CW +: CW]
//   pwm_out      registered PWM outputs
//   pending      captured values waiting for the next update point
//   loaded       one-cycle pulse when the shadow registers change
//   frame_start  one-cycle pulse aligned with the pwm_out cycle that
//                reflects cnt==0 (outputs lag the counter by one cycle)
// Build option: define PWM_CENTER_ALIGNED_EN for up/down (center-aligned)
// counting; default is edge-aligned counting with no direction register.
// -----------------------------------------------------------------------------
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CH         = CH_DEF,
  parameter int CW         = CW_DEF,
  parameter int PERIOD_RST = PERIOD_RST_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             en,
  input  logic             load,
  input  logic [CW-1:0]    period_in,
  input  logic [CH*CW-1:0] duty_in,
  output logic [CH-1:0]    pwm_out,
  output logic             pending,
  output logic             loaded,
  output logic             frame_start
);

  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_stg_q, per_stg_d;
  logic [CW-1:0] per_sh_q, per_sh_d;
  logic          pend_q, pend_d;
  logic          loaded_q, loaded_d;
  logic          fs_q, fs_d;
  logic          wrap_s, upd_s;
`ifdef PWM_CENTER_ALIGNED_EN
  logic          up_q, up_d;
`endif

  // Frame boundary and shadow update point.
  always_comb begin
`ifdef PWM_CENTER_ALIGNED_EN
    wrap_s = (cnt_q == CNT_ZERO) && !up_q;
`else
    wrap_s = (cnt_q == per_sh_q);
`endif
    // While stopped every clock is an update point, so pending values land at once.
    upd_s = en ? wrap_s : 1'b1;
  end

  // Period staging/shadow, pending/loaded handshake and frame_start.
  always_comb begin
    per_stg_d = per_stg_q;
    per_sh_d  = per_sh_q;
    pend_d    = pend_q;
    loaded_d  = 1'b0;
    fs_d      = 1'b0;
    if (load) begin
      per_stg_d = period_in;
    end else begin
      per_stg_d = per_stg_q;
    end
    if (upd_s && load) begin
      per_sh_d = period_in;
    end else if (upd_s && pend_q) begin
      per_sh_d = per_stg_q;
    end else begin
      per_sh_d = per_sh_q;
    end
    if (upd_s) begin
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    loaded_d = upd_s && (load || pend_q);
    fs_d     = en && (cnt_q == CNT_ZERO);
  end

  // Shared frame counter.
  always_comb begin
    cnt_d = cnt_q;
`ifdef PWM_CENTER_ALIGNED_EN
    up_d = up_q;
    if (!en) begin
      cnt_d = CNT_ZERO;
      up_d  = 1'b0;
    end else if (up_q) begin
      if (cnt_q >= per_sh_q) begin
        cnt_d = cnt_q - CNT_ONE;
        up_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        up_d  = 1'b1;
      end
    end else if (cnt_q == CNT_ZERO) begin
      // Frame boundary: the period taking effect now decides whether to climb.
      if (per_sh_d == CNT_ZERO) begin
        cnt_d = CNT_ZERO;
        up_d  = 1'b0;
      end else begin
        cnt_d = CNT_ONE;
        up_d  = 1'b1;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
      up_d  = 1'b0;
    end
`else
    if (!en || wrap_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
`endif
  end

  // Top-level state registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q     <= CNT_ZERO;
      per_stg_q <= CNT_ZERO;
      per_sh_q  <= CW'(PERIOD_RST);
      pend_q    <= 1'b0;
      loaded_q  <= 1'b0;
      fs_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      up_q      <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      per_stg_q <= per_stg_d;
      per_sh_q  <= per_sh_d;
      pend_q    <= pend_d;
      loaded_q  <= loaded_d;
      fs_q      <= fs_d;
`ifdef PWM_CENTER_ALIGNED_EN
      up_q      <= up_d;
`endif
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pwm_cmp_ch #(
      .CW(CW)
    ) u_ch (
      .clk_i   (CLK),
      .rst_n_i (RSTn),
      .en_i    (en),
      .load_i  (load),
      .upd_i   (upd_s),
      .pend_i  (pend_q),
      .cnt_i   (cnt_q),
      .duty_i  (duty_in[duty_lsb(k, CW) +: CW]),
      .pwm_o   (pwm_out[k])
    );
  end

  assign pending     = pend_q;
  assign loaded      = loaded_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
// Directed bench for pwm_multi_channel. Each load pushes the expected frame
// (period + duties) into a scoreboard queue; once the DUT applies it, the
// entry is popped and whole frames are compared cycle by cycle.
// Honours PWM_CENTER_ALIGNED_EN to pick the expected counting shape.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

  localparam int CH = 4;
  localparam int CW = 13;

  typedef struct packed {
    logic [CW-1:0]          p;
    logic [CH-1:0][CW-1:0]  d;
  } frame_exp_t;

  logic             CLK;
  logic             RSTn;
  logic             en;
  logic             load;
  logic [CW-1:0]    period_in;
  logic [CH*CW-1:0] duty_in;
  logic [CH-1:0]    pwm_out;
  logic             pending;
  logic             loaded;
  logic             frame_start;

  int vectors     = 0;
  int miscompares = 0;
  frame_exp_t sb_q[$];

  pwm_multi_channel #(
    .CH(CH), .CW(CW), .PERIOD_RST(4999)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .en          (en),
    .load        (load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .pwm_out     (pwm_out),
    .pending     (pending),
    .loaded      (loaded),
    .frame_start (frame_start)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Counter value at position pos of a frame with terminal count p.
  function automatic int pos_cnt(input int pos, input int p);
`ifdef PWM_CENTER_ALIGNED_EN
    return (pos <= p) ? pos : (2 * p - pos);
`else
    return pos;
`endif
  endfunction

  function automatic int frame_len(input int p);
`ifdef PWM_CENTER_ALIGNED_EN
    return (p == 0) ? 1 : 2 * p;
`else
    return p + 1;
`endif
  endfunction

  task automatic push_exp(input int p, input int d0, input int d1, input int d2, input int d3);
    frame_exp_t e;
    e.p    = CW'(p);
    e.d[0] = CW'(d0);
    e.d[1] = CW'(d1);
    e.d[2] = CW'(d2);
    e.d[3] = CW'(d3);
    sb_q.push_back(e);
  endtask

  // One-cycle load strobe; replace=1 means this load supersedes the previous one.
  task automatic load_vals(input int p, input int d0, input int d1, input int d2,
                           input int d3, input bit replace);
    if (replace && sb_q.size() > 0) void'(sb_q.pop_back());
    push_exp(p, d0, d1, d2, d3);
    load      = 1'b1;
    period_in = sb_q[$].p;
    duty_in   = sb_q[$].d;
    step();
    load      = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 6000) begin
      step();
      n++;
    end
    if (frame_start !== 1'b1) chk($sformatf("%s_fs_timeout", tag), int'(frame_start), 1);
  endtask

  task automatic wait_loaded(input string tag);
    int n = 0;
    while (loaded !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("%s_loaded", tag), int'(loaded), 1);
  endtask

  // Measure one full frame and compare length and every output cycle.
  task automatic check_frame(input string tag, input frame_exp_t e);
    int p, len;
    int bad[CH];
    p   = int'(e.p);
    bad = '{default: 0};
    wait_fs(tag);
    len = 0;
    do begin
      for (int k = 0; k < CH; k++) begin
        if (pwm_out[k] !== (pos_cnt(len, p) < int'(e.d[k]))) bad[k]++;
      end
      step();
      len++;
    end while (frame_start !== 1'b1 && len < 6000);
    chk($sformatf("%s_len", tag), len, frame_len(p));
    for (int k = 0; k < CH; k++) chk($sformatf("%s_ch%0d_badcycles", tag, k), bad[k], 0);
  endtask

  initial begin
    frame_exp_t cur;
    int n;
    int nl;
    RSTn      = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    period_in = '0;
    duty_in   = '0;
    repeat (3) @(negedge CLK);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_frame_start", int'(frame_start), 0);

`ifdef PWM_CENTER_ALIGNED_EN
    RSTn = 1'b1;
    step();
    load_vals(4, 2, 0, 5, 4, 1'b0);
    chk("c_loaded", int'(loaded), 1);
    chk("c_pending", int'(pending), 0);
    cur = sb_q.pop_front();
    en  = 1'b1;
    repeat (3) check_frame("c_frame", cur);
`else
    // Load during the long reset-period frame; applies at its wrap.
    RSTn = 1'b1;
    en   = 1'b1;
    step();
    load_vals(9, 3, 0, 0, 0, 1'b0);
    chk("t1_pending", int'(pending), 1);
    n = 0;
    while (loaded !== 1'b1 && n < 6000) begin
      step();
      n++;
    end
    chk("t1_load_latency", n, 4998);
    chk("t1_pending_clr", int'(pending), 0);
    cur = sb_q.pop_front();
    repeat (3) check_frame("t1_frame", cur);

    // 0% and 100% duty, plus D==P and a mid value.
    load_vals(9, 0, 10, 9, 5, 1'b0);
    wait_loaded("t2");
    cur = sb_q.pop_front();
    repeat (2) check_frame("t2_frame", cur);

    // Two loads in one frame (cnt=4 then cnt=6): last wins, one loaded pulse.
    repeat (3) step();
    load_vals(9, 5, 10, 9, 5, 1'b0);
    chk("t3_pending", int'(pending), 1);
    step();
    load_vals(9, 7, 10, 9, 5, 1'b1);
    nl = 0;
    n  = 0;
    while (frame_start !== 1'b1 && n < 40) begin
      step();
      n++;
      nl += int'(loaded);
    end
    chk("t3_loaded_pulses", nl, 1);
    chk("t3_pending_clr", int'(pending), 0);
    cur = sb_q.pop_front();
    check_frame("t3_frame", cur);

    // Load on the wrap cycle (cnt=9): straight to shadow, pending stays low.
    repeat (8) step();
    load_vals(9, 2, 10, 9, 5, 1'b0);
    chk("t4_loaded", int'(loaded), 1);
    chk("t4_pending", int'(pending), 0);
    cur = sb_q.pop_front();
    check_frame("t4_frame", cur);
    chk("t4_pending_after", int'(pending), 0);

    // Reset at cnt=6 with a pending load: all cleared, pending discarded.
    repeat (3) step();
    load_vals(9, 8, 0, 0, 0, 1'b0);
    step();
    chk("t5_pending_pre", int'(pending), 1);
    chk("t5_pwm_pre", int'(pwm_out), 6);
    #1 RSTn = 1'b0;
    #1;
    chk("t5_rst_pwm_out", int'(pwm_out), 0);
    chk("t5_rst_pending", int'(pending), 0);
    chk("t5_rst_loaded", int'(loaded), 0);
    chk("t5_rst_frame_start", int'(frame_start), 0);
    void'(sb_q.pop_back());
    push_exp(4999, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    cur  = sb_q.pop_front();
    check_frame("t5_post_rst", cur);
    chk("t5_pending_after", int'(pending), 0);

    // Dropping en applies a pending load on the next clock; restart from cnt=0.
    load_vals(9, 6, 1, 0, 9, 1'b0);
    chk("t6_pending", int'(pending), 1);
    en = 1'b0;
    step();
    chk("t6_loaded", int'(loaded), 1);
    chk("t6_pending_clr", int'(pending), 0);
    chk("t6_pwm_off", int'(pwm_out), 0);
    chk("t6_fs_off", int'(frame_start), 0);
    step();
    chk("t6_loaded_once", int'(loaded), 0);
    en  = 1'b1;
    cur = sb_q.pop_front();
    repeat (2) check_frame("t6_frame", cur);

    // P=0: every cycle is a frame; output is simply D>0.
    en = 1'b0;
    step();
    load_vals(0, 1, 0, 3, 0, 1'b0);
    chk("t7_loaded", int'(loaded), 1);
    en  = 1'b1;
    cur = sb_q.pop_front();
    repeat (4) check_frame("t7_frame", cur);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
